// File: rtl/uart_imem_loader.sv
// UART (8N1) program loader: receives a little-endian word count and instruction words,
// writes them to instruction memory and holds the core in reset until the load completes.
module uart_imem_loader #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned ADDR_WIDTH   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  load_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned   TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF    = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT - 1);
  localparam logic [32:0]   MAX_WORDS = 33'(1) << ADDR_WIDTH;

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  logic rx_s1, rx_s2, rx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          byte_valid, byte_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      tmr      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      rx_state <= rx_state_n;
      tmr      <= tmr_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    tmr_n      = tmr + 1'b1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if (load_req) begin
      rx_state_n = RX_IDLE;
      tmr_n      = '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          tmr_n = '0;
          if (rx_d && !rx_s2) rx_state_n = RX_START;
        end
        RX_START: begin
          if (tmr == T_HALF) begin
            tmr_n      = '0;
            bit_idx_n  = '0;
            rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (tmr == T_FULL) begin
            tmr_n     = '0;
            shreg_n   = {rx_s2, shreg[7:1]};
            bit_idx_n = bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state_n = RX_STOP;
          end
        end
        RX_STOP: begin
          if (tmr == T_FULL) begin
            tmr_n      = '0;
            byte_valid = 1'b1;
            byte_err   = !rx_s2;
            rx_state_n = RX_IDLE;
          end
        end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  typedef enum logic [2:0] {IDLE, HDR, BODY, DONE, ERR} state_t;

  state_t                state, state_n;
  logic [1:0]            byte_cnt, byte_cnt_n;
  logic [23:0]           word_buf, word_buf_n;
  logic [31:0]           n_words, n_words_n;
  logic [ADDR_WIDTH:0]   word_cnt, word_cnt_n;
  logic                  imem_we_n;
  logic [ADDR_WIDTH-1:0] imem_addr_n;
  logic [31:0]           imem_wdata_n;
  logic [31:0]           word_full;

  assign word_full = {shreg, word_buf};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      word_buf   <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      word_buf   <= word_buf_n;
      n_words    <= n_words_n;
      word_cnt   <= word_cnt_n;
      imem_we    <= imem_we_n;
      imem_addr  <= imem_addr_n;
      imem_wdata <= imem_wdata_n;
    end
  end

  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    word_buf_n   = word_buf;
    n_words_n    = n_words;
    word_cnt_n   = word_cnt;
    imem_we_n    = 1'b0;
    imem_addr_n  = imem_addr;
    imem_wdata_n = imem_wdata;
    if (load_req) begin
      state_n    = HDR;
      byte_cnt_n = '0;
      word_cnt_n = '0;
    end else if (state == HDR || state == BODY) begin
      // word_cnt already counts the word being strobed, so DONE lands the cycle after the write
      if (state == BODY && imem_we && 32'(word_cnt) == n_words) begin
        state_n = DONE;
      end else if (byte_valid && byte_err) begin
        state_n = ERR;
      end else if (byte_valid) begin
        byte_cnt_n = byte_cnt + 1'b1;
        case (byte_cnt)
          2'd0: word_buf_n[7:0]   = shreg;
          2'd1: word_buf_n[15:8]  = shreg;
          2'd2: word_buf_n[23:16] = shreg;
          default: begin
            if (state == HDR) begin
              n_words_n = word_full;
              if (word_full == '0)                     state_n = DONE;
              else if ({1'b0, word_full} > MAX_WORDS)  state_n = ERR;
              else                                     state_n = BODY;
            end else begin
              imem_we_n    = 1'b1;
              imem_addr_n  = word_cnt[ADDR_WIDTH-1:0];
              imem_wdata_n = word_full;
              word_cnt_n   = word_cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign busy    = (state == HDR) || (state == BODY);
  assign done    = (state == DONE);
  assign err     = (state == ERR);
  assign cpu_rst = busy || err;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: byte-level behavioural model of the load protocol,
// per-cycle write/hold checking and directed plus randomized UART frames.
module tb_uart_imem_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx;
  logic          load_req;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst, busy, done, err;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_req(load_req),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_HDR, M_BODY, M_DONE, M_ERR} mphase_t;
  typedef struct { int unsigned addr; logic [31:0] data; } wr_t;

  mphase_t     m_phase;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_n;
  int unsigned m_words;
  wr_t         exp_q[$];
  int unsigned exp_addr;
  logic [31:0] exp_data;
  logic [31:0] mem_seen [0:15];
  int unsigned wr_count;
  bit          settled, chk_done_next;
  int unsigned n_cmp, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // {cpu_rst, busy, done, err} implied by the protocol phase
  function automatic logic [3:0] exp_status();
    case (m_phase)
      M_HDR, M_BODY: return 4'b1100;
      M_DONE:        return 4'b0010;
      M_ERR:         return 4'b1001;
      default:       return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    m_bytes.delete();
    exp_q.delete();
    m_words = 0;
    exp_addr = 0;
    exp_data = '0;
    chk_done_next = 0;
  endtask

  task automatic model_load();
    m_phase = M_HDR;
    m_bytes.delete();
    exp_q.delete();
    m_words = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    wr_t w;
    if (m_phase != M_HDR && m_phase != M_BODY) return;
    if (!stop_ok) begin
      m_phase = M_ERR;
      m_bytes.delete();
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() < 4) return;
    w.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
    m_bytes.delete();
    if (m_phase == M_HDR) begin
      m_n = w.data;
      m_words = 0;
      if (m_n == 0)                    m_phase = M_DONE;
      else if (m_n > 32'(1 << AW))     m_phase = M_ERR;
      else                             m_phase = M_BODY;
    end else begin
      w.addr = m_words;
      exp_q.push_back(w);
      m_words++;
      if (m_words == m_n) m_phase = M_DONE;
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0) begin
      if (chk_done_next) begin
        chk_done_next = 0;
        check("done_after_last_write", 32'({cpu_rst, busy, done, err}), 32'(4'b0010));
      end
      if (imem_we === 1'b1) begin
        wr_count++;
        mem_seen[imem_addr] = imem_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", imem_wdata, e.data);
          check("done_not_early", 32'(done), 32'(0));
          exp_addr = e.addr;
          exp_data = e.data;
          if (exp_q.size() == 0 && m_phase == M_DONE) chk_done_next = 1;
        end
      end else begin
        check("hold_addr", 32'(imem_addr), 32'(exp_addr));
        check("hold_data", imem_wdata, exp_data);
      end
      if (settled) check("status", 32'({cpu_rst, busy, done, err}), 32'(exp_status()));
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    settled = 0;
    model_byte(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    drive_bit(1'b1);
    settled = 1;
    check("missing_write", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic send_word(input logic [31:0] w, input bit last_stop_ok);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], (i == 3) ? last_stop_ok : 1'b1);
  endtask

  task automatic pulse_load();
    settled = 0;
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    model_load();
    tick(2);
    settled = 1;
  endtask

  task automatic glitch(input int unsigned len);
    uart_rx = 1'b0;
    tick(len);
    uart_rx = 1'b1;
    tick(2 * CPB);
  endtask

  initial begin
    int unsigned wr0, nn, eb, kind, k;
    logic [7:0] b8;
    rst = 1'b1; uart_rx = 1'b1; load_req = 1'b0;
    settled = 0; wr_count = 0; n_cmp = 0; n_bad = 0; m_n = '0;
    for (int i = 0; i < 16; i++) mem_seen[i] = 32'hDEAD_BEEF;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_status", 32'({cpu_rst, busy, done, err, imem_we}), 32'(0));
    check("reset_addr", 32'(imem_addr), 32'(0));
    check("reset_wdata", imem_wdata, 32'(0));
    settled = 1;

    // async reset in the middle of a header byte; later bytes must be ignored
    pulse_load();
    send_byte(8'h02, 1'b1);
    settled = 0;
    uart_rx = 1'b0; tick(CPB); drive_bit(1'b1); drive_bit(1'b0);
    #3 rst = 1'b1;
    #1;
    check("rst_async_status", 32'({cpu_rst, busy, done, err, imem_we}), 32'(0));
    check("rst_async_addr", 32'(imem_addr), 32'(0));
    model_reset();
    uart_rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    settled = 1;
    wr0 = wr_count;
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h1234_5678, 1'b1);
    check("ignored_after_rst_writes", 32'(wr_count - wr0), 32'(0));
    check("ignored_after_rst_status", 32'({cpu_rst, busy, done, err}), 32'(0));

    // two-word program
    pulse_load();
    wr0 = wr_count;
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h0010_0513, 1'b1);
    send_word(32'h0020_0593, 1'b1);
    check("prog_word0", mem_seen[0], 32'h0010_0513);
    check("prog_word1", mem_seen[1], 32'h0020_0593);
    check("prog_nwrites", 32'(wr_count - wr0), 32'(2));
    check("prog_status", 32'({cpu_rst, busy, done, err}), 32'(4'b0010));

    // empty program, then a short glitch on the idle line in DONE
    pulse_load();
    wr0 = wr_count;
    send_word(32'h0000_0000, 1'b1);
    check("n0_status", 32'({cpu_rst, busy, done, err}), 32'(4'b0010));
    glitch(5);
    check("n0_nwrites", 32'(wr_count - wr0), 32'(0));

    // too many words
    pulse_load();
    wr0 = wr_count;
    send_word(32'h0000_0011, 1'b1);
    check("n17_status", 32'({cpu_rst, busy, done, err}), 32'(4'b1001));
    send_word(32'hAABB_CCDD, 1'b1);
    check("n17_nwrites", 32'(wr_count - wr0), 32'(0));

    // full depth: addresses 0..15
    pulse_load();
    wr0 = wr_count;
    send_word(32'h0000_0010, 1'b1);
    for (int i = 0; i < 16; i++) send_word($urandom, 1'b1);
    check("n16_nwrites", 32'(wr_count - wr0), 32'(16));
    check("n16_status", 32'({cpu_rst, busy, done, err}), 32'(4'b0010));

    // framing error on the word-completing byte
    pulse_load();
    wr0 = wr_count;
    send_word(32'h0000_0001, 1'b1);
    send_word(32'hDDCC_BBAA, 1'b0);
    check("ferr_status", 32'({cpu_rst, busy, done, err}), 32'(4'b1001));
    check("ferr_nwrites", 32'(wr_count - wr0), 32'(0));

    // glitch in BODY, then load_req mid-byte restarts header parsing
    pulse_load();
    send_word(32'h0000_0002, 1'b1);
    send_word(32'hCAFE_0001, 1'b1);
    glitch(6);
    settled = 0;
    b8 = 8'h35;
    uart_rx = 1'b0; tick(CPB);
    for (int i = 0; i < 3; i++) drive_bit(b8[i]);
    uart_rx = b8[3];
    tick(CPB / 2);
    pulse_load();
    uart_rx = 1'b1;
    tick(2 * CPB);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h1234_5678, 1'b1);
    check("restart_word0", mem_seen[0], 32'h1234_5678);
    check("restart_status", 32'({cpu_rst, busy, done, err}), 32'(4'b0010));

    for (int it = 0; it < 6; it++) begin
      pulse_load();
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        nn = 17 + $urandom_range(0, 1000);
        if ($urandom_range(0, 1) == 1) nn = $urandom | 32'h0100_0000;
        send_word(nn, 1'b1);
      end else if (kind == 1) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < 4; j++) send_byte(8'($urandom), (j != k));
      end else begin
        nn = $urandom_range(1, 4);
        eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * nn - 1) : 999;
        send_word(nn, 1'b1);
        for (int j = 0; j < int'(4 * nn); j++) send_byte(8'($urandom), (j != int'(eb)));
      end
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) glitch($urandom_range(1, 6));
    end

    settled = 0;
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
